// File: rtl/dncnt_pkg.sv
// Shared definitions for the cascadable down-counter chain.
//   NIB_W      : width of one counter stage
//   stage_op_e : per-stage operation, priority CLR > LOAD > DEC > HOLD
//   stage_op() : priority encoder for the per-stage operation
package dncnt_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_DEC  = 2'd2,
        OP_CLR  = 2'd3
    } stage_op_e;

    // Clear beats load, load beats count; count needs both enable and borrow-in.
    function automatic stage_op_e stage_op(
        input logic cl,
        input logic nl,
        input logic en,
        input logic bi
    );
        stage_op_e op;
        op = OP_HOLD;
        if (cl) begin
            op = OP_CLR;
        end else if (!nl) begin
            op = OP_LOAD;
        end else if (en && bi) begin
            op = OP_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/dncnt_chain_stage.sv
// One 4-bit synchronous down-counter stage.
//   CK  : clock            CL : synchronous active-high clear
//   D   : load value       nL : active-low synchronous load
//   EN  : count enable     BI : borrow-in (stage counts on EN & BI)
//   Q   : count value      BO : borrow-out = BI & (Q == 0), combinational
module dncnt_stage
    import dncnt_pkg::*;
(
    input  logic             CK,
    input  logic             CL,
    input  logic [NIB_W-1:0] D,
    input  logic             nL,
    input  logic             EN,
    input  logic             BI,
    output logic [NIB_W-1:0] Q,
    output logic             BO
);

    stage_op_e op_c;

    assign op_c = stage_op(CL, nL, EN, BI);

    // Decrement wraps 0 -> F naturally through modular subtraction.
    always_ff @(posedge CK) begin
        case (op_c)
            OP_CLR:  Q <= '0;
            OP_LOAD: Q <= D;
            OP_DEC:  Q <= Q - NIB_W'(1);
            default: Q <= Q;
        endcase
    end

    // Independent of EN so a disabled stage still passes the borrow along.
    assign BO = BI & (Q == '0);

endmodule

// File: rtl/dncnt_chain.sv
// Cascadable binary down-counter built from STAGES 4-bit stages.
//   CK : clock                      CL : synchronous active-high clear
//   D  : parallel load/reload value nL : active-low synchronous load
//   EN : count enable               BI : borrow-in from a lower chain
//   Q  : count value (W = 4*STAGES) BO : borrow-out = BI & (Q == 0), combinational
//   TC : registered one-cycle underflow pulse
// RELOAD=1 reloads D on underflow, RELOAD=0 wraps to all-ones.
// TCO/TBO are simulation timing annotations only and do not affect the logic.
module dncnt_chain
    import dncnt_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int RELOAD = 0,
    parameter int TCO    = 1,
    parameter int TBO    = 3
) (
    input  logic                      CK,
    input  logic                      CL,
    input  logic [NIB_W*STAGES-1:0]   D,
    input  logic                      nL,
    input  logic                      EN,
    input  logic                      BI,
    output logic [NIB_W*STAGES-1:0]   Q,
    output logic                      BO,
    output logic                      TC
);

    localparam int unsigned W         = NIB_W * STAGES;
    localparam bit          RELOAD_EN = (RELOAD != 0);

    if (STAGES < 1 || STAGES > 8 || TCO < 0 || TBO < 0) begin : g_bad_param
        $error("dncnt_chain: STAGES must be 1..8 and delays non-negative");
    end

    // brw[k] is the borrow into stage k; brw[STAGES] is the chain borrow-out.
    logic [STAGES:0] brw;
    logic            uf_c;
    logic            reload_c;
    logic            st_nl_c;

    assign brw[0] = BI;

    // Underflow: whole chain at zero with a live count request and no load/clear.
    assign uf_c     = brw[STAGES] & EN & nL & ~CL;
    assign reload_c = RELOAD_EN & uf_c;
    assign st_nl_c  = nL & ~reload_c;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        dncnt_stage u_stage (
            .CK (CK),
            .CL (CL),
            .D  (D[k*NIB_W +: NIB_W]),
            .nL (st_nl_c),
            .EN (EN),
            .BI (brw[k]),
            .Q  (Q[k*NIB_W +: NIB_W]),
            .BO (brw[k+1])
        );
    end

    assign BO = brw[STAGES];

    // Terminal-count pulse: high for the cycle following each underflow edge.
    always_ff @(posedge CK) begin
        if (CL) begin
            TC <= 1'b0;
        end else begin
            TC <= uf_c;
        end
    end

    logic unused_w;
    assign unused_w = ^W;

endmodule

// File: tb/tb_dncnt_chain.sv
// Randomized and directed bench for dncnt_chain: one wrapping (RELOAD=0) and
// one reloading (RELOAD=1) 8-bit instance share stimulus and are compared
// against an arithmetic reference model.
module tb_dncnt_chain;

    localparam int unsigned W = 8;

    logic         ck;
    logic         cl;
    logic [W-1:0] d;
    logic         nl;
    logic         en;
    logic         bi;
    logic [W-1:0] q0, q1;
    logic         bo0, bo1, tc0, tc1;

    int n_vec;
    int n_err;

    // Reference model state: index 0 wraps, index 1 reloads.
    int unsigned m_q  [2];
    int unsigned m_tc [2];

    dncnt_chain #(.STAGES(2), .RELOAD(0), .TCO(1), .TBO(3)) u_dut_wrap (
        .CK (ck), .CL (cl), .D (d), .nL (nl), .EN (en), .BI (bi),
        .Q  (q0), .BO (bo0), .TC (tc0)
    );

    dncnt_chain #(.STAGES(2), .RELOAD(1), .TCO(1), .TBO(3)) u_dut_rld (
        .CK (ck), .CL (cl), .D (d), .nL (nl), .EN (en), .BI (bi),
        .Q  (q1), .BO (bo1), .TC (tc1)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Next-state rules written directly from the counter's behaviour.
    function automatic void model_edge(input int idx);
        if (cl) begin
            m_q[idx]  = 0;
            m_tc[idx] = 0;
        end else if (!nl) begin
            m_q[idx]  = d;
            m_tc[idx] = 0;
        end else if (en && bi) begin
            if (m_q[idx] == 0) begin
                m_q[idx]  = (idx == 1) ? int'(d) : (1 << W) - 1;
                m_tc[idx] = 1;
            end else begin
                m_q[idx]  = m_q[idx] - 1;
                m_tc[idx] = 0;
            end
        end else begin
            m_tc[idx] = 0;
        end
    endfunction

    // Apply inputs, check the combinational borrow, clock once, check state.
    task automatic step(input logic s_cl, input logic s_nl, input logic s_en,
                        input logic s_bi, input logic [W-1:0] s_d);
        cl = s_cl; nl = s_nl; en = s_en; bi = s_bi; d = s_d;
        #1;
        check_eq("bo_wrap", bo0, (bi && m_q[0] == 0) ? 1 : 0);
        check_eq("bo_rld",  bo1, (bi && m_q[1] == 0) ? 1 : 0);
        @(posedge ck);
        model_edge(0);
        model_edge(1);
        #1;
        check_eq("q_wrap",  q0,  m_q[0]);
        check_eq("tc_wrap", tc0, m_tc[0]);
        check_eq("q_rld",   q1,  m_q[1]);
        check_eq("tc_rld",  tc1, m_tc[1]);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_q[0] = 0; m_q[1] = 0; m_tc[0] = 0; m_tc[1] = 0;
        cl = 1'b0; nl = 1'b1; en = 1'b0; bi = 1'b0; d = '0;

        // Reach an arbitrary state, then clear it.
        @(posedge ck); #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, W'(8'hA7));
        step(1'b1, 1'b1, 1'b1, 1'b1, W'(8'h3C));
        check_eq("reset_q", q0, 0);
        check_eq("reset_tc", tc0, 0);

        // Load 0x12 and count through zero into the wrap.
        step(1'b0, 1'b0, 1'b0, 1'b0, W'(8'h12));
        for (int i = 0; i < 'h13; i++) step(1'b0, 1'b1, 1'b1, 1'b1, W'(8'h12));
        check_eq("wrap_q_ff", q0, 'hFF);
        check_eq("wrap_tc", tc0, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, W'(8'h12));

        // Reload from D=3 on underflow.
        step(1'b0, 1'b0, 1'b0, 1'b0, W'(8'h03));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, W'(8'h03));
        check_eq("reload_q", q1, 3);
        check_eq("reload_tc", tc1, 1);

        // Back-to-back underflows with D=0.
        step(1'b0, 1'b0, 1'b0, 1'b0, W'(8'h00));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, W'(8'h00));
        check_eq("b2b_tc", tc1, 1);

        // Load beats underflow at Q=0.
        step(1'b1, 1'b1, 1'b0, 1'b0, W'(8'h00));
        step(1'b0, 1'b0, 1'b1, 1'b1, W'(8'h55));
        check_eq("load_win_q", q0, 'h55);
        check_eq("load_win_tc", tc0, 0);

        // Borrow-out independence from EN and no partial-zero borrow.
        step(1'b1, 1'b1, 1'b0, 1'b0, W'(8'h00));
        step(1'b0, 1'b1, 1'b0, 1'b1, W'(8'h00));
        step(1'b0, 1'b1, 1'b0, 1'b0, W'(8'h00));
        step(1'b0, 1'b0, 1'b0, 1'b0, W'(8'h10));
        step(1'b0, 1'b1, 1'b0, 1'b1, W'(8'h10));

        // Clear mid-count, then first count underflows.
        step(1'b0, 1'b0, 1'b0, 1'b0, W'(8'h0A));
        step(1'b0, 1'b1, 1'b1, 1'b1, W'(8'h0A));
        step(1'b0, 1'b1, 1'b1, 1'b1, W'(8'h0A));
        step(1'b1, 1'b1, 1'b1, 1'b1, W'(8'h0A));
        step(1'b0, 1'b1, 1'b1, 1'b1, W'(8'h0A));
        check_eq("clr_rel_q", q0, 'hFF);
        check_eq("clr_rel_tc", tc0, 1);

        // Random traffic, biased toward counting and small load values.
        for (int i = 0; i < 3000; i++) begin
            logic r_cl, r_nl, r_en, r_bi;
            logic [W-1:0] r_d;
            r_cl = ($urandom_range(0, 31) == 0);
            r_nl = ($urandom_range(0, 7) != 0);
            r_en = ($urandom_range(0, 3) != 0);
            r_bi = ($urandom_range(0, 3) != 0);
            r_d  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            step(r_cl, r_nl, r_en, r_bi, r_d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
